// File: rtl/sys_sched_if.sv
// Command/status and buffer-read bundle between layer controller and sys_sched.
// reuse_w exists only when SYS_SCHED_WREUSE_EN is defined.
interface sys_sched_if #(
   parameter int SYS_ROWS = 5,
   parameter int SYS_COLS = 3,
   parameter int VEC_W    = 10,
   parameter int WADDR_W  = 3
);
   logic                start;
   logic [VEC_W-1:0]    n_vec;
`ifdef SYS_SCHED_WREUSE_EN
   logic                reuse_w;
`endif
   logic                busy;
   logic                done;
   logic                w_rd_en;
   logic [WADDR_W-1:0]  w_rd_addr;
   logic                a_rd_en;
   logic [VEC_W-1:0]    a_rd_addr;
   logic [SYS_COLS-1:0] wfetch;
   logic [SYS_ROWS-1:0] if_en;
   logic [SYS_COLS-1:0] of_valid;

   modport master (
      output start, n_vec,
`ifdef SYS_SCHED_WREUSE_EN
      output reuse_w,
`endif
      input  busy, done, w_rd_en, w_rd_addr,
      input  a_rd_en, a_rd_addr, wfetch, if_en, of_valid
   );

   modport slave (
      input  start, n_vec,
`ifdef SYS_SCHED_WREUSE_EN
      input  reuse_w,
`endif
      output busy, done, w_rd_en, w_rd_addr,
      output a_rd_en, a_rd_addr, wfetch, if_en, of_valid
   );
endinterface

// File: rtl/sys_sched.sv
// Tile sequencer for the weight-stationary systolic MAC array.
// Optional weight reuse (skip WLOAD) enabled by SYS_SCHED_WREUSE_EN.
module sys_sched #(
   parameter int SYS_ROWS = 5,
   parameter int SYS_COLS = 3,
   parameter int VEC_W    = 10,
   parameter int WADDR_W  = 3
) (
   input logic       i_clk,
   input logic       i_rst,
   sys_sched_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_STREAM,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam logic [WADDR_W-1:0] W_LAST = WADDR_W'(SYS_ROWS - 1);
   localparam logic [VEC_W:0]     D_LAST = (VEC_W+1)'(SYS_ROWS + SYS_COLS);

   state_t              r_state;
   logic [VEC_W-1:0]    r_n;
   logic [VEC_W:0]      r_vcnt;
   logic [VEC_W:0]      r_dcnt;
   logic                r_busy;
   logic                r_done;
   logic                r_w_rd_en;
   logic [WADDR_W-1:0]  r_w_rd_addr;
   logic                r_a_rd_en;
   logic [VEC_W-1:0]    r_a_rd_addr;
   logic [SYS_COLS-1:0] r_wfetch;
   logic [SYS_ROWS-1:0] r_if_en;
   logic [SYS_COLS-1:0] r_of_valid;

   logic                w_reuse;
   logic [SYS_ROWS:0]   w_if_cat;
   logic [SYS_COLS:0]   w_of_cat;

`ifdef SYS_SCHED_WREUSE_EN
   assign w_reuse = bus.reuse_w;
`else
   assign w_reuse = 1'b0;
`endif

   // Row r sees the read one cycle later than row r-1; columns likewise.
   assign w_if_cat = {r_if_en, r_a_rd_en};
   assign w_of_cat = {r_of_valid, r_if_en[SYS_ROWS-1]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_vcnt      <= '0;
         r_dcnt      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_w_rd_en   <= 1'b0;
         r_w_rd_addr <= '0;
         r_a_rd_en   <= 1'b0;
         r_a_rd_addr <= '0;
         r_wfetch    <= '0;
         r_if_en     <= '0;
         r_of_valid  <= '0;
      end else begin
         r_done     <= 1'b0;
         r_wfetch   <= {SYS_COLS{r_w_rd_en}};
         r_if_en    <= w_if_cat[SYS_ROWS-1:0];
         r_of_valid <= w_of_cat[SYS_COLS-1:0];
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.n_vec == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_n    <= bus.n_vec;
                     r_busy <= 1'b1;
                     if (w_reuse) begin
                        r_state     <= S_STREAM;
                        r_a_rd_en   <= 1'b1;
                        r_a_rd_addr <= '0;
                        r_vcnt      <= (VEC_W+1)'(1);
                     end else begin
                        r_state     <= S_WLOAD;
                        r_w_rd_en   <= 1'b1;
                        r_w_rd_addr <= '0;
                     end
                  end
               end
            end
            S_WLOAD: begin
               // One idle cycle after the last read lets its data land.
               if (r_w_rd_en) begin
                  if (r_w_rd_addr == W_LAST) begin
                     r_w_rd_en   <= 1'b0;
                     r_w_rd_addr <= '0;
                  end else begin
                     r_w_rd_addr <= r_w_rd_addr + 1'b1;
                  end
               end else begin
                  r_state     <= S_STREAM;
                  r_a_rd_en   <= 1'b1;
                  r_a_rd_addr <= '0;
                  r_vcnt      <= (VEC_W+1)'(1);
               end
            end
            S_STREAM: begin
               if (r_vcnt == {1'b0, r_n}) begin
                  r_state     <= S_DRAIN;
                  r_a_rd_en   <= 1'b0;
                  r_a_rd_addr <= '0;
                  r_dcnt      <= (VEC_W+1)'(1);
               end else begin
                  r_a_rd_addr <= r_a_rd_addr + 1'b1;
                  r_vcnt      <= r_vcnt + 1'b1;
               end
            end
            S_DRAIN: begin
               // Last vector needs R+C cycles to clear the final column.
               if (r_dcnt == D_LAST) begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.w_rd_en   = r_w_rd_en;
   assign bus.w_rd_addr = r_w_rd_addr;
   assign bus.a_rd_en   = r_a_rd_en;
   assign bus.a_rd_addr = r_a_rd_addr;
   assign bus.wfetch    = r_wfetch;
   assign bus.if_en     = r_if_en;
   assign bus.of_valid  = r_of_valid;

endmodule

// File: tb/tb_sys_sched.sv
// Scoreboard bench for sys_sched: driver queues per-cycle expected outputs,
// negedge monitor pops and compares.
module tb_sys_sched;

   localparam int R = 5;
   localparam int C = 3;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       w_rd_en;
      logic [2:0] w_rd_addr;
      logic       a_rd_en;
      logic [9:0] a_rd_addr;
      logic [2:0] wfetch;
      logic [4:0] if_en;
      logic [2:0] of_valid;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sys_sched_if #(.SYS_ROWS(R), .SYS_COLS(C), .VEC_W(10), .WADDR_W(3)) bus ();

   sys_sched #(.SYS_ROWS(R), .SYS_COLS(C), .VEC_W(10), .WADDR_W(3)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   out_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   int   g       = 0;
   int   ts      = -1;
   int   ts_n    = 0;
   bit   ts_rw   = 1'b0;

   // Timing model: cycle k after the accepted start.
   function automatic out_t model(int k, int n, bit rw);
      out_t o;
      int   s;
      int   dc;
      o = '0;
      if (k < 1) return o;
      if (n == 0) begin
         o.done = (k == 1);
         return o;
      end
      if (!rw && k <= R) begin
         o.w_rd_en   = 1'b1;
         o.w_rd_addr = 3'(k - 1);
      end
      if (!rw && k >= 2 && k <= R + 1) o.wfetch = '1;
      s = rw ? 1 : R + 2;
      if (k >= s && k < s + n) begin
         o.a_rd_en   = 1'b1;
         o.a_rd_addr = 10'(k - s);
      end
      for (int r = 0; r < R; r++)
         if (k >= s + 1 + r && k < s + 1 + r + n) o.if_en[r] = 1'b1;
      for (int c = 0; c < C; c++)
         if (k >= s + R + 1 + c && k < s + R + 1 + c + n) o.of_valid[c] = 1'b1;
      dc = s + n + R + C;
      o.busy = (k <= dc);
      o.done = (k == dc);
      return o;
   endfunction

   task automatic step(input bit st, input int n, input bit rw, input bit rs);
      out_t e;
      bit   rw_eff;
      @(posedge clk);
      #1;
      e = (ts < 0) ? '0 : model(g - ts, ts_n, ts_rw);
      exp_q.push_back(e);
      mon_en = 1'b1;
`ifdef SYS_SCHED_WREUSE_EN
      rw_eff = rw;
      bus.reuse_w = rw;
`else
      rw_eff = 1'b0 & rw;
`endif
      bus.start = st;
      bus.n_vec = n[9:0];
      rst = rs;
      if (rs) ts = -1;
      else if (st && !e.busy) begin
         ts    = g;
         ts_n  = n;
         ts_rw = rw_eff;
      end
      g++;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) step(1'b0, 9, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         out_t a;
         out_t e;
         a = {bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.a_rd_en,
              bus.a_rd_addr, bus.wfetch, bus.if_en, bus.of_valid};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty cyc=%0d: no expected entry", g);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d got b%b d%b w%b/%0d a%b/%0d wf%b if%b of%b want b%b d%b w%b/%0d a%b/%0d wf%b if%b of%b",
                        g - 1, a.busy, a.done, a.w_rd_en, a.w_rd_addr, a.a_rd_en,
                        a.a_rd_addr, a.wfetch, a.if_en, a.of_valid,
                        e.busy, e.done, e.w_rd_en, e.w_rd_addr, e.a_rd_en,
                        e.a_rd_addr, e.wfetch, e.if_en, e.of_valid);
            end
         end
      end
   end

   initial begin
      bus.start = 1'b0;
      bus.n_vec = '0;
`ifdef SYS_SCHED_WREUSE_EN
      bus.reuse_w = 1'b0;
`endif
      repeat (2) @(posedge clk);
      step(1'b0, 0, 1'b0, 1'b0);
      idle(10);

      // Full tile n=4; restart at 10 ignored, at 20 accepted.
      step(1'b1, 4, 1'b0, 1'b0);
      for (int i = 1; i < 45; i++) begin
         if (i == 10) step(1'b1, 7, 1'b0, 1'b0);
         else if (i == 20) step(1'b1, 4, 1'b0, 1'b0);
         else step(1'b0, 9, 1'b0, 1'b0);
      end

      // Empty tile.
      step(1'b1, 0, 1'b0, 1'b0);
      idle(4);

      // Single-vector tile.
      step(1'b1, 1, 1'b0, 1'b0);
      idle(20);

      // Reset mid-tile at cycle 9, new start at 11.
      step(1'b1, 4, 1'b0, 1'b0);
      for (int i = 1; i < 9; i++) step(1'b0, 9, 1'b0, 1'b0);
      step(1'b0, 9, 1'b0, 1'b1);
      step(1'b0, 9, 1'b0, 1'b0);
      step(1'b1, 4, 1'b0, 1'b0);
      idle(22);

`ifdef SYS_SCHED_WREUSE_EN
      step(1'b1, 2, 1'b1, 1'b0);
      idle(14);
      step(1'b1, 3, 1'b0, 1'b0);
      idle(24);
`endif

      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
